// File: rtl/mdio_phy_responder.sv
// mdio_phy_responder: PHY-side Clause-22 MDIO management responder.
//
// Oversamples MDC/MDIO on the system clock, decodes read/write frames addressed
// to PHY_ADDR, keeps a 32x16 register file (regs 2/3 read back PHY_ID) and
// drives read data onto the pad through a tristate enable.
//
// Ports:
//   clk, areset          system clock (>= 8x MDC), async active-high reset
//   mdc, mdio_i          management clock and pad input from the master
//   mdio_o, mdio_oe      pad output value and output enable (1 = drive)
//   host_addr/host_rdata host read port, 1 clk latency
//   wr_pulse/wr_addr/wr_data  commit strobe and last committed write
//   frame_err            pulse on a malformed frame addressed to this PHY
//
// Optional feature: define MDIO_PRE_SUPPRESS_EN to let a frame follow a
// successfully completed frame without a preamble.

module mdio_phy_responder #(
    parameter logic [4:0]  PHY_ADDR    = 5'b10000,
    parameter logic [31:0] PHY_ID      = 32'h0141_0CC2,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        areset,
    input  logic        mdc,
    input  logic        mdio_i,
    output logic        mdio_o,
    output logic        mdio_oe,
    input  logic [4:0]  host_addr,
    output logic [15:0] host_rdata,
    output logic        wr_pulse,
    output logic [4:0]  wr_addr,
    output logic [15:0] wr_data,
    output logic        frame_err
);

`ifdef MDIO_PRE_SUPPRESS_EN
    localparam bit PRE_SUPPRESS = 1'b1;
`else
    localparam bit PRE_SUPPRESS = 1'b0;
`endif

    typedef enum logic [2:0] {
        StIdle, StStart, StOp, StPhyad, StRegad, StTa, StWdata, StRdata
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] mdc_sync;
    logic [SYNC_STAGES-1:0] mdio_sync;
    logic                   mdc_prev;
    logic [5:0]             pre_cnt;
    logic [4:0]             bit_cnt;
    logic [14:0]            shift;     // older samples; current sample is appended
    logic                   is_read;
    logic [4:0]             reg_addr;
    logic [15:0]            rd_word;
    logic                   armed;     // preamble may be skipped for the next frame
    logic [15:0]            regs [32];

    logic mdc_s, mdio_s, rise, fall;

    assign mdc_s  = mdc_sync[SYNC_STAGES-1];
    assign mdio_s = mdio_sync[SYNC_STAGES-1];
    assign rise   = mdc_s & ~mdc_prev;
    assign fall   = ~mdc_s & mdc_prev;

    function automatic logic [15:0] reg_read(input logic [4:0] a);
        if (a == 5'd2) begin
            return PHY_ID[31:16];
        end else if (a == 5'd3) begin
            return PHY_ID[15:0];
        end else begin
            return regs[a];
        end
    endfunction

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state      <= StIdle;
            mdc_sync   <= '0;
            mdio_sync  <= '1;
            mdc_prev   <= 1'b0;
            pre_cnt    <= '0;
            bit_cnt    <= '0;
            shift      <= '0;
            is_read    <= 1'b0;
            reg_addr   <= '0;
            rd_word    <= '0;
            armed      <= 1'b0;
            mdio_o     <= 1'b1;
            mdio_oe    <= 1'b0;
            host_rdata <= '0;
            wr_pulse   <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            frame_err  <= 1'b0;
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else begin
            mdc_sync   <= {mdc_sync[SYNC_STAGES-2:0], mdc};
            mdio_sync  <= {mdio_sync[SYNC_STAGES-2:0], mdio_i};
            mdc_prev   <= mdc_s;
            wr_pulse   <= 1'b0;
            frame_err  <= 1'b0;
            host_rdata <= reg_read(host_addr);

            unique case (state)
                StIdle: begin
                    if (fall) begin
                        if (mdio_s) begin
                            if (pre_cnt != 6'd32) begin
                                pre_cnt <= pre_cnt + 6'd1;
                            end
                        end else begin
                            pre_cnt <= '0;
                            if ((pre_cnt == 6'd32) || armed) begin
                                // Re-armed only by a successful completion.
                                armed <= 1'b0;
                                state <= StStart;
                            end
                        end
                    end
                end

                StStart: begin
                    if (fall) begin
                        bit_cnt <= '0;
                        state   <= mdio_s ? StOp : StIdle;
                    end
                end

                StOp: begin
                    if (fall) begin
                        shift   <= {shift[13:0], mdio_s};
                        bit_cnt <= bit_cnt + 5'd1;
                        if (bit_cnt == 5'd1) begin
                            bit_cnt <= '0;
                            unique case ({shift[0], mdio_s})
                                2'b01: begin
                                    is_read <= 1'b0;
                                    state   <= StPhyad;
                                end
                                2'b10: begin
                                    is_read <= 1'b1;
                                    state   <= StPhyad;
                                end
                                default: state <= StIdle;
                            endcase
                        end
                    end
                end

                StPhyad: begin
                    if (fall) begin
                        shift   <= {shift[13:0], mdio_s};
                        bit_cnt <= bit_cnt + 5'd1;
                        if (bit_cnt == 5'd4) begin
                            bit_cnt <= '0;
                            state   <= ({shift[3:0], mdio_s} == PHY_ADDR) ? StRegad : StIdle;
                        end
                    end
                end

                StRegad: begin
                    if (fall) begin
                        shift   <= {shift[13:0], mdio_s};
                        bit_cnt <= bit_cnt + 5'd1;
                        if (bit_cnt == 5'd4) begin
                            bit_cnt  <= '0;
                            reg_addr <= {shift[3:0], mdio_s};
                            if (is_read) begin
                                rd_word <= reg_read({shift[3:0], mdio_s});
                            end
                            state <= StTa;
                        end
                    end
                end

                StTa: begin
                    if (is_read) begin
                        // First TA bit: stay off the bus; second: drive 0.
                        if (rise) begin
                            bit_cnt <= bit_cnt + 5'd1;
                            if (bit_cnt == 5'd1) begin
                                bit_cnt <= '0;
                                mdio_oe <= 1'b1;
                                mdio_o  <= 1'b0;
                                state   <= StRdata;
                            end
                        end
                    end else if (fall) begin
                        shift   <= {shift[13:0], mdio_s};
                        bit_cnt <= bit_cnt + 5'd1;
                        if (bit_cnt == 5'd1) begin
                            bit_cnt <= '0;
                            if ({shift[0], mdio_s} == 2'b10) begin
                                state <= StWdata;
                            end else begin
                                frame_err <= 1'b1;
                                state     <= StIdle;
                            end
                        end
                    end
                end

                StWdata: begin
                    if (fall) begin
                        shift   <= {shift[13:0], mdio_s};
                        bit_cnt <= bit_cnt + 5'd1;
                        if (bit_cnt == 5'd15) begin
                            bit_cnt  <= '0;
                            wr_pulse <= 1'b1;
                            wr_addr  <= reg_addr;
                            wr_data  <= {shift, mdio_s};
                            if ((reg_addr == 5'd0) && shift[14]) begin
                                // Soft reset; reg0[15] self-clears as a result.
                                for (int i = 0; i < 32; i++) begin
                                    regs[i] <= '0;
                                end
                            end else if ((reg_addr != 5'd2) && (reg_addr != 5'd3)) begin
                                regs[reg_addr] <= {shift, mdio_s};
                            end
                            armed <= PRE_SUPPRESS;
                            state <= StIdle;
                        end
                    end
                end

                StRdata: begin
                    if (rise) begin
                        if (bit_cnt == 5'd16) begin
                            mdio_oe <= 1'b0;
                            mdio_o  <= 1'b1;
                            bit_cnt <= '0;
                            armed   <= PRE_SUPPRESS;
                            state   <= StIdle;
                        end else begin
                            mdio_o  <= rd_word[15];
                            rd_word <= {rd_word[14:0], 1'b0};
                            bit_cnt <= bit_cnt + 5'd1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdio_phy_responder.sv
// Directed self-checking bench for mdio_phy_responder. A behavioural MDIO
// master launches bits on MDC rising edges and samples the line just before
// the next rising edge. Define MDIO_PRE_SUPPRESS_EN to check the optional
// preamble-suppression behaviour.

module tb_mdio_phy_responder;

    logic        clk = 1'b0;
    logic        areset;
    logic        mdc;
    logic        mdio_line;
    logic        mdio_o;
    logic        mdio_oe;
    logic [4:0]  host_addr;
    logic [15:0] host_rdata;
    logic        wr_pulse;
    logic [4:0]  wr_addr;
    logic [15:0] wr_data;
    logic        frame_err;

    logic m_val;
    logic m_oe;
    logic s_oe;
    logic s_o;

    int n_tests = 0;
    int n_fail  = 0;
    int wr_cnt  = 0;
    int err_cnt = 0;
    int oe_clks = 0;

    // Bus: responder wins when driving, else master, else pull-up.
    assign mdio_line = mdio_oe ? mdio_o : (m_oe ? m_val : 1'b1);

    always #5 clk = ~clk;

    mdio_phy_responder dut (
        .clk        (clk),
        .areset     (areset),
        .mdc        (mdc),
        .mdio_i     (mdio_line),
        .mdio_o     (mdio_o),
        .mdio_oe    (mdio_oe),
        .host_addr  (host_addr),
        .host_rdata (host_rdata),
        .wr_pulse   (wr_pulse),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .frame_err  (frame_err)
    );

    always @(posedge clk) begin
        if (wr_pulse === 1'b1) wr_cnt <= wr_cnt + 1;
        if (frame_err === 1'b1) err_cnt <= err_cnt + 1;
        if (mdio_oe === 1'b1) oe_clks <= oe_clks + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One MDC period: launch at rise, sample line at end of low phase.
    task automatic mdc_cycle(input logic b, input logic drv);
        mdc  = 1'b1;
        m_val = b;
        m_oe  = drv;
        #80;
        mdc = 1'b0;
        #79;
        s_oe = mdio_oe;
        s_o  = mdio_line;
        #1;
    endtask

    task automatic preamble(input int n);
        for (int i = 0; i < n; i++) mdc_cycle(1'b1, 1'b1);
    endtask

    task automatic write_frame(input logic [4:0] phy, input logic [4:0] ra,
                               input logic [1:0] ta, input logic [15:0] d, input int pre);
        logic [31:0] f;
        f = {2'b01, 2'b01, phy, ra, ta, d};
        preamble(pre);
        for (int i = 31; i >= 0; i--) mdc_cycle(f[i], 1'b1);
        m_oe = 1'b0;
    endtask

    task automatic read_header(input logic [4:0] ra);
        logic [13:0] h;
        h = {2'b01, 2'b10, 5'b10000, ra};
        preamble(32);
        for (int i = 13; i >= 0; i--) mdc_cycle(h[i], 1'b1);
        m_oe = 1'b0;
    endtask

    task automatic read_frame(input logic [4:0] ra, output logic [15:0] word,
                              output int oe_periods, output logic ta_bit);
        read_header(ra);
        word       = '0;
        oe_periods = 0;
        ta_bit     = 1'bx;
        for (int j = 0; j < 19; j++) begin
            mdc_cycle(1'b1, 1'b0);
            if (s_oe) oe_periods++;
            if (j == 1) ta_bit = s_o;
            if (j >= 2 && j <= 17) word = {word[14:0], s_o};
        end
    endtask

    task automatic host_read(input logic [4:0] a, output logic [15:0] v);
        host_addr = a;
        @(posedge clk);
        @(posedge clk);
        #1;
        v = host_rdata;
        #4;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] word;
        logic [15:0] hv;
        logic        ta_bit;
        int          oe_periods;
        int          w0, e0, o0;

        areset    = 1'b1;
        mdc       = 1'b0;
        m_val     = 1'b1;
        m_oe      = 1'b0;
        host_addr = 5'd0;
        #20;
        check("rst_oe", {31'b0, mdio_oe}, 32'd0);
        check("rst_o", {31'b0, mdio_o}, 32'd1);
        check("rst_wr_pulse", {31'b0, wr_pulse}, 32'd0);
        check("rst_frame_err", {31'b0, frame_err}, 32'd0);
        check("rst_wr_addr", {27'b0, wr_addr}, 32'd0);
        check("rst_wr_data", {16'b0, wr_data}, 32'd0);
        check("rst_host_rdata", {16'b0, host_rdata}, 32'd0);
        #20;
        areset = 1'b0;
        #40;

        // Basic write to reg 16.
        w0 = wr_cnt; e0 = err_cnt; o0 = oe_clks;
        write_frame(5'b10000, 5'd16, 2'b10, 16'h0060, 32);
        check("wr16_pulses", wr_cnt - w0, 32'd1);
        check("wr16_addr", {27'b0, wr_addr}, 32'd16);
        check("wr16_data", {16'b0, wr_data}, 32'h0060);
        check("wr16_err", err_cnt - e0, 32'd0);
        check("wr16_oe", oe_clks - o0, 32'd0);
        host_read(5'd16, hv);
        check("wr16_host", {16'b0, hv}, 32'h0060);

        // ID register reads.
        o0 = oe_clks;
        read_frame(5'd2, word, oe_periods, ta_bit);
        check("rd2_word", {16'b0, word}, 32'h0141);
        check("rd2_oe_periods", oe_periods, 32'd17);
        check("rd2_ta", {31'b0, ta_bit}, 32'd0);
        check("rd2_oe_clks", oe_clks - o0, 32'd272);
        check("rd2_release_oe", {31'b0, mdio_oe}, 32'd0);
        check("rd2_release_o", {31'b0, mdio_o}, 32'd1);
        read_frame(5'd3, word, oe_periods, ta_bit);
        check("rd3_word", {16'b0, word}, 32'h0CC2);
        check("rd3_oe_periods", oe_periods, 32'd17);

        // Wrong PHY address.
        w0 = wr_cnt; e0 = err_cnt; o0 = oe_clks;
        write_frame(5'b00001, 5'd16, 2'b10, 16'hFFFF, 32);
        check("badphy_pulses", wr_cnt - w0, 32'd0);
        check("badphy_err", err_cnt - e0, 32'd0);
        check("badphy_oe", oe_clks - o0, 32'd0);
        host_read(5'd16, hv);
        check("badphy_host16", {16'b0, hv}, 32'h0060);

        // 31-bit preamble (after a 0 that clears the count) is not enough.
        w0 = wr_cnt; e0 = err_cnt;
        mdc_cycle(1'b0, 1'b1);
        write_frame(5'b10000, 5'd16, 2'b10, 16'h1234, 31);
        check("pre31_pulses", wr_cnt - w0, 32'd0);
        check("pre31_err", err_cnt - e0, 32'd0);
        host_read(5'd16, hv);
        check("pre31_host16", {16'b0, hv}, 32'h0060);

        // Bad write turnaround.
        w0 = wr_cnt; e0 = err_cnt;
        write_frame(5'b10000, 5'd16, 2'b11, 16'h5555, 32);
        check("ta11_err", err_cnt - e0, 32'd1);
        check("ta11_pulses", wr_cnt - w0, 32'd0);
        host_read(5'd16, hv);
        check("ta11_host16", {16'b0, hv}, 32'h0060);

        // Write to read-only reg 2: strobes but is discarded.
        w0 = wr_cnt;
        write_frame(5'b10000, 5'd2, 2'b10, 16'hFFFF, 32);
        check("ro2_pulses", wr_cnt - w0, 32'd1);
        check("ro2_wr_addr", {27'b0, wr_addr}, 32'd2);
        host_read(5'd2, hv);
        check("ro2_host", {16'b0, hv}, 32'h0141);

        // Reg 0 without and with the soft-reset bit.
        write_frame(5'b10000, 5'd0, 2'b10, 16'h1140, 32);
        host_read(5'd0, hv);
        check("reg0_plain", {16'b0, hv}, 32'h1140);
        w0 = wr_cnt;
        write_frame(5'b10000, 5'd0, 2'b10, 16'h8140, 32);
        check("reg0_rst_pulses", wr_cnt - w0, 32'd1);
        check("reg0_rst_wr_data", {16'b0, wr_data}, 32'h8140);
        host_read(5'd0, hv);
        check("reg0_rst_host0", {16'b0, hv}, 32'h0000);
        host_read(5'd16, hv);
        check("reg0_rst_host16", {16'b0, hv}, 32'h0000);

        // Reset in the middle of a read releases the bus at once.
        write_frame(5'b10000, 5'd16, 2'b10, 16'hBEEF, 32);
        read_header(5'd16);
        for (int j = 0; j < 9; j++) mdc_cycle(1'b1, 1'b0);
        mdc = 1'b1;
        #40;
        check("midrd_oe_before", {31'b0, mdio_oe}, 32'd1);
        areset = 1'b1;
        #1;
        check("midrd_oe_after", {31'b0, mdio_oe}, 32'd0);
        check("midrd_o_after", {31'b0, mdio_o}, 32'd1);
        #19;
        areset = 1'b0;
        mdc = 1'b0;
        #80;
        read_frame(5'd3, word, oe_periods, ta_bit);
        check("postrst_rd3", {16'b0, word}, 32'h0CC2);
        check("postrst_oe_periods", oe_periods, 32'd17);
        read_frame(5'd16, word, oe_periods, ta_bit);
        check("postrst_rd16", {16'b0, word}, 32'h0000);

        // Back-to-back writes, the second without a preamble.
        w0 = wr_cnt;
        write_frame(5'b10000, 5'd17, 2'b10, 16'h1111, 32);
        write_frame(5'b10000, 5'd18, 2'b10, 16'h2222, 0);
        host_read(5'd17, hv);
        check("b2b_host17", {16'b0, hv}, 32'h1111);
        host_read(5'd18, hv);
`ifdef MDIO_PRE_SUPPRESS_EN
        check("b2b_pulses", wr_cnt - w0, 32'd2);
        check("b2b_host18", {16'b0, hv}, 32'h2222);
`else
        check("b2b_pulses", wr_cnt - w0, 32'd1);
        check("b2b_host18", {16'b0, hv}, 32'h0000);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mdio_phy_responder.md
Name: mdio_phy_responder

Overview:
- PHY-side Clause-22 MDIO management responder: the slave end that decodes station-management frames from an MDIO master.
- Oversamples MDC/MDIO on the system clock and decodes write and read frames addressed to PHY_ADDR.
- Writes update an internal 32x16 register file; reads return register contents on MDIO via a tristate enable.
- Sits between the board MDIO pins and PHY configuration logic; exposes a host read port and a write-notify strobe.

Parameters:
- PHY_ADDR, 5'b10000: PHY address this responder answers to.
- PHY_ID, 32'h0141_0CC2: value returned by read-only reg 2 (bits 31:16) and reg 3 (bits 15:0).
- SYNC_STAGES, 2: synchronizer depth for mdc and mdio_i (minimum 2).

Ports:
- clk, in, 1: system clock; must be >= 8x MDC frequency.
- areset, in, 1: asynchronous active-high reset.
- mdc, in, 1: management clock from the master (asynchronous to clk).
- mdio_i, in, 1: MDIO pad input.
- mdio_o, out, 1: MDIO pad output value.
- mdio_oe, out, 1: MDIO pad output enable; 1 = drive.
- host_addr, in, 5: host-side register read address.
- host_rdata, out, 16: register[host_addr], registered with 1 clk latency.
- wr_pulse, out, 1: one-clk pulse when an MDIO write commits.
- wr_addr, out, 5: register address of the last committed write.
- wr_data, out, 16: data of the last committed write.
- frame_err, out, 1: one-clk pulse on a malformed frame addressed to this PHY.

Behaviour:
- Reset clears everything asynchronously:
  - FSM goes to IDLE.
  - mdio_oe=0, mdio_o=1, wr_pulse=0, frame_err=0, wr_addr=0, wr_data=0, host_rdata=0.
  - Preamble counter is cleared and all writable registers are set to 0.
- Edge detection on synchronized mdc:
  - R = rising-edge event, F = falling-edge event.
  - MDIO is sampled at F, because the master launches on the MDC rising edge.
  - Responder output changes at R.
- Wire bit order:
  - ST = 0,1.
  - OP write = 0,1; OP read = 1,0.
  - PHYAD and REGAD are sent MSB first.
  - Write TA = 1,0.
  - DATA is sent MSB first.
- FSM states: IDLE, START, OP, PHYAD, REGAD, TA, WDATA, RDATA.
- IDLE:
  - Count consecutive sampled 1s, saturating at 32; any sampled 0 with count < 32 clears the count.
  - A sampled 0 with count = 32 moves to START.
- START: the next sample must be 1.
  - If 1, go to OP.
  - Otherwise return to IDLE with count = 0; no frame_err, because the PHY address is not yet known.
- OP: capture 2 bits.
  - 00 or 11 returns to IDLE.
- PHYAD: capture 5 bits.
  - A mismatch with PHY_ADDR returns to IDLE silently; the bus is never driven.
- REGAD: capture 5 bits.
  - On the last bit of a read, latch the read word:
    - reg 2 gives PHY_ID[31:16]; reg 3 gives PHY_ID[15:0].
    - Other addresses return register content.
- TA, write frame: samples must be 1,0.
  - Otherwise pulse frame_err and return to IDLE.
- TA, read frame:
  - mdio_oe stays 0 for the first TA bit.
  - At the R starting the second TA bit, mdio_oe=1 and mdio_o=0.
- RDATA:
  - The next 16 R events drive bits 15..0.
  - At the R after bit 0's period: mdio_oe=0, mdio_o=1, then IDLE.
  - mdio_oe is high for exactly 17 MDC periods.
- WDATA:
  - Shift 16 samples.
  - At the F of bit 0, commit the write and pulse wr_pulse for 1 clk with wr_addr/wr_data updated; then IDLE.
  - Writes to regs 2 and 3 are discarded but still pulse wr_pulse.
  - A write to reg 0 with bit 15 = 1 resets all writable registers to 0; reg0[15] reads 0 (self-clearing).
- Every frame needs a fresh 32-bit preamble; the preamble count restarts at IDLE entry.
- Host port: host_rdata follows a host_addr change on the next clk.
  - A same-cycle MDIO commit is visible one clk later.
- areset mid-read releases the bus immediately (async).

Optional Feature:
- MDIO_PRE_SUPPRESS_EN defined:
  - After one successfully completed frame addressed to this PHY, the next frame may start without preamble: a 0 sampled in IDLE goes to START.
  - Any malformed frame or areset re-arms the full 32-bit preamble requirement.
- Undefined: 32-bit preamble is mandatory for every frame.

Test Plan:
- Write, PHYAD=10000, REGAD=16, data 16'h0060 → wr_pulse once, wr_addr=16, wr_data=16'h0060; host_addr=16 gives host_rdata=16'h0060; mdio_oe stays 0 throughout.
- Read of REGAD=2 → mdio_oe high 17 MDC periods; wire carries 0 then 16'h0141 MSB first. Read of REGAD=3 → 16'h0CC2.
- Frame with PHYAD=00001 (write 16'hFFFF to reg 16) → no wr_pulse, no frame_err, reg 16 unchanged, mdio_oe=0.
- 31-bit preamble followed by a valid write → ignored. Write with TA=1,1 → frame_err pulse, no commit.
- Write reg 0 = 16'h8140 after reg 16 = 16'h0060 → all writable registers read 0, reg 0 reads 16'h0000.
- areset asserted at RDATA bit 8 → mdio_oe=0 immediately; next valid read frame returns correct data.
- With MDIO_PRE_SUPPRESS_EN: two back-to-back writes, the second without preamble → both commit. Without the macro → the second is ignored.
